// File: rtl/ave_read_addr_gen_if.sv
// Bus between the average-pooling read address generator and its environment.
// The slave side is the generator; the master side drives start/config/readDone.
interface ave_read_addr_gen_if #(
    parameter int ADDR_W = 12,
    parameter int LANES  = 9,
    parameter int SIZE_W = 12,
    parameter int CH_W   = 10
);
    logic                      i_start;
    logic [ADDR_W-1:0]         i_baseAddr;
    logic [SIZE_W-1:0]         i_mapSize;
    logic [CH_W-1:0]           i_numChannels;
    logic                      i_readDone;
    logic [LANES*ADDR_W-1:0]   o_addrAve;
    logic                      o_startReadAve;
    logic [LANES-1:0]          o_laneMask;
    logic                      o_lastOfChannel;
    logic                      o_busy;
    logic                      o_done;

    modport master (
        output i_start, i_baseAddr, i_mapSize, i_numChannels, i_readDone,
        input  o_addrAve, o_startReadAve, o_laneMask, o_lastOfChannel, o_busy, o_done
    );

    modport slave (
        input  i_start, i_baseAddr, i_mapSize, i_numChannels, i_readDone,
        output o_addrAve, o_startReadAve, o_laneMask, o_lastOfChannel, o_busy, o_done
    );
endinterface

// File: rtl/ave_read_addr_gen.sv
// Walks a channel-major feature map and issues LANES-wide packed read bursts,
// one outstanding burst at a time, for the average-pooling source-RAM read path.
module ave_read_addr_gen #(
    parameter int ADDR_W = 12,
    parameter int LANES  = 9,
    parameter int SIZE_W = 12,
    parameter int CH_W   = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ave_read_addr_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    localparam logic [SIZE_W:0] LANES_W = (SIZE_W + 1)'(LANES);

    state_t                    state_q, state_d;
    logic [SIZE_W-1:0]         mapSize_q, mapSize_d;
    logic [CH_W-1:0]           numCh_q, numCh_d;
    logic [SIZE_W:0]           pix_q, pix_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [ADDR_W-1:0]         chBase_q, chBase_d;
    logic [LANES*ADDR_W-1:0]   addr_q, addr_d;
    logic [LANES-1:0]          mask_q, mask_d;
    logic                      last_q, last_d;
    logic                      start_q, start_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      issue;
    logic [SIZE_W-1:0]         eff_map;
    logic [CH_W-1:0]           eff_ch;
    logic [SIZE_W:0]           rem;
    logic [SIZE_W:0]           nvalid;
    logic [ADDR_W-1:0]         burst_base;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            mapSize_q <= '0;
            numCh_q   <= '0;
            pix_q     <= '0;
            ch_q      <= '0;
            chBase_q  <= '0;
            addr_q    <= '0;
            mask_q    <= '0;
            last_q    <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mapSize_q <= mapSize_d;
            numCh_q   <= numCh_d;
            pix_q     <= pix_d;
            ch_q      <= ch_d;
            chBase_q  <= chBase_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            last_q    <= last_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mapSize_d = mapSize_q;
        numCh_d   = numCh_q;
        pix_d     = pix_q;
        ch_d      = ch_q;
        chBase_d  = chBase_q;
        addr_d    = addr_q;
        mask_d    = mask_q;
        last_d    = last_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        issue     = 1'b0;

        // Zero-sized maps or channel counts are clamped to 1 so a pass always ends.
        eff_map = (bus.i_mapSize == '0) ? SIZE_W'(1) : bus.i_mapSize;
        eff_ch  = (bus.i_numChannels == '0) ? CH_W'(1) : bus.i_numChannels;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    mapSize_d = eff_map;
                    numCh_d   = eff_ch;
                    pix_d     = '0;
                    ch_d      = '0;
                    chBase_d  = bus.i_baseAddr;
                    busy_d    = 1'b1;
                    issue     = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.i_readDone) begin
                    if (!last_q) begin
                        pix_d   = pix_q + LANES_W;
                        issue   = 1'b1;
                        state_d = S_ISSUE;
                    end else if (ch_q < numCh_q - 1'b1) begin
                        ch_d     = ch_q + 1'b1;
                        pix_d    = '0;
                        chBase_d = chBase_q + ADDR_W'(mapSize_q);
                        issue    = 1'b1;
                        state_d  = S_ISSUE;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Burst is built from the post-update counters so it is registered on the
        // same edge that enters ISSUE; this gives the one-cycle start/readDone latency.
        rem        = {1'b0, mapSize_d} - pix_d;
        nvalid     = (rem < LANES_W) ? rem : LANES_W;
        burst_base = chBase_d + ADDR_W'(pix_d);

        if (issue) begin
            start_d = 1'b1;
            last_d  = (rem <= LANES_W);
            for (int unsigned k = 0; k < LANES; k++) begin
                if ((SIZE_W + 1)'(k) < nvalid) begin
                    addr_d[k*ADDR_W +: ADDR_W] = burst_base + ADDR_W'(k);
                    mask_d[k]                  = 1'b1;
                end else begin
                    addr_d[k*ADDR_W +: ADDR_W] = burst_base + ADDR_W'(nvalid - 1'b1);
                    mask_d[k]                  = 1'b0;
                end
            end
        end
    end

    assign bus.o_addrAve       = addr_q;
    assign bus.o_startReadAve  = start_q;
    assign bus.o_laneMask      = mask_q;
    assign bus.o_lastOfChannel = last_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_done          = done_q;

endmodule

// File: tb/tb_ave_read_addr_gen.sv
// Randomized self-checking bench for ave_read_addr_gen: a burst-list model built
// from map geometry is compared against the DUT on every cycle.
module tb_ave_read_addr_gen;

    localparam int ADDR_W = 12;
    localparam int LANES  = 9;
    localparam int SIZE_W = 12;
    localparam int CH_W   = 10;

    typedef struct packed {
        logic [LANES*ADDR_W-1:0] addr;
        logic [LANES-1:0]        mask;
        logic                    last;
    } burst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ave_read_addr_gen_if #(.ADDR_W(ADDR_W), .LANES(LANES), .SIZE_W(SIZE_W), .CH_W(CH_W)) bus ();

    ave_read_addr_gen #(.ADDR_W(ADDR_W), .LANES(LANES), .SIZE_W(SIZE_W), .CH_W(CH_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     errors  = 0;
    bit     chk_en  = 1'b0;
    logic   exp_start = 1'b0;
    logic   exp_done  = 1'b0;
    logic   exp_busy  = 1'b0;
    burst_t cur       = '0;
    burst_t exp_q[$];
    burst_t log_q[$];
    burst_t t1_log[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lane(input logic [LANES*ADDR_W-1:0] a, input int k);
        logic [ADDR_W-1:0] v;
        v = a[k*ADDR_W +: ADDR_W];
        return int'(v);
    endfunction

    // Per-cycle comparison of every DUT output against the model expectation.
    task automatic compare();
        burst_t seen;
        if (!chk_en) return;
        check("startRead", bus.o_startReadAve, exp_start);
        check("done", bus.o_done, exp_done);
        check("busy", bus.o_busy, exp_busy);
        if (bus.o_startReadAve === 1'b1) begin
            check("burst_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            seen.addr = bus.o_addrAve;
            seen.mask = bus.o_laneMask;
            seen.last = bus.o_lastOfChannel;
            log_q.push_back(seen);
        end
        check("addr", bus.o_addrAve, cur.addr);
        check("mask", bus.o_laneMask, cur.mask);
        check("lastOfChannel", bus.o_lastOfChannel, cur.last);
    endtask

    task automatic slot();
        @(negedge clk);
        compare();
        #1;
    endtask

    // Enumerate the bursts of a pass straight from the map geometry.
    task automatic build_model(input int base, input int map, input int nch);
        burst_t b;
        int     cb;
        int     idx;
        if (map == 0) map = 1;
        if (nch == 0) nch = 1;
        for (int c = 0; c < nch; c++) begin
            cb = base + c * map;
            for (int p = 0; p < map; p += LANES) begin
                b = '0;
                for (int k = 0; k < LANES; k++) begin
                    idx = p + k;
                    if (idx < map) b.mask[k] = 1'b1;
                    else           idx = map - 1;
                    b.addr[k*ADDR_W +: ADDR_W] = ADDR_W'((cb + idx) % 4096);
                end
                b.last = (p + LANES >= map);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic run_pass(input int base, input int map, input int nch, input int maxd,
                            input bit noisy, input int rst_at, input int fixed_d);
        int nb;
        int d;
        log_q.delete();
        build_model(base, map, nch);
        nb = exp_q.size();
        bus.i_baseAddr    = ADDR_W'(base);
        bus.i_mapSize     = SIZE_W'(map);
        bus.i_numChannels = CH_W'(nch);
        bus.i_start = 1'b1;
        exp_start   = 1'b1;
        exp_busy    = 1'b1;
        slot();
        bus.i_start = 1'b0;
        exp_start   = 1'b0;
        for (int b = 0; b < nb; b++) begin
            // This slot is sampled while the DUT sits in ISSUE.
            bus.i_readDone = noisy;
            bus.i_start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            slot();
            bus.i_readDone = 1'b0;
            bus.i_start    = 1'b0;
            if (b == rst_at) begin
                rst       = 1'b1;
                exp_busy  = 1'b0;
                exp_q.delete();
                cur       = '0;
                slot();
                rst            = 1'b0;
                bus.i_readDone = 1'b1;
                slot();
                bus.i_readDone = 1'b0;
                repeat (3) slot();
                return;
            end
            d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, maxd));
            repeat (d) begin
                bus.i_start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                slot();
            end
            bus.i_start    = 1'b0;
            bus.i_readDone = 1'b1;
            if (b < nb - 1) begin
                exp_start = 1'b1;
            end else begin
                exp_done = 1'b1;
                exp_busy = 1'b0;
            end
            slot();
            bus.i_readDone = 1'b0;
            exp_start      = 1'b0;
            exp_done       = 1'b0;
        end
        slot();
        check("bursts_consumed", exp_q.size(), 0);
    endtask

    initial begin
        int lit[LANES];

        bus.i_start       = 1'b0;
        bus.i_readDone    = 1'b0;
        bus.i_baseAddr    = '0;
        bus.i_mapSize     = '0;
        bus.i_numChannels = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        slot();
        slot();
        rst = 1'b0;
        slot();

        // T1: 49-pixel single channel.
        run_pass(0, 49, 1, 2, 1'b0, -1, -1);
        check("t1_nbursts", log_q.size(), 6);
        if (log_q.size() == 6) begin
            check("t1_b0_lane0", lane(log_q[0].addr, 0), 0);
            check("t1_b0_lane8", lane(log_q[0].addr, 8), 8);
            check("t1_b0_mask", log_q[0].mask, 9'h1FF);
            check("t1_b4_lane8", lane(log_q[4].addr, 8), 44);
            check("t1_b4_last", log_q[4].last, 1'b0);
            lit = '{45, 46, 47, 48, 48, 48, 48, 48, 48};
            for (int k = 0; k < LANES; k++) check("t1_b5_lane", lane(log_q[5].addr, k), lit[k]);
            check("t1_b5_mask", log_q[5].mask, 9'h00F);
            check("t1_b5_last", log_q[5].last, 1'b1);
        end
        t1_log = log_q;

        // T2: three 9-pixel channels.
        run_pass(100, 9, 3, 3, 1'b0, -1, -1);
        check("t2_nbursts", log_q.size(), 3);
        if (log_q.size() == 3) begin
            lit = '{100, 109, 118, 0, 0, 0, 0, 0, 0};
            for (int b = 0; b < 3; b++) begin
                check("t2_lane0", lane(log_q[b].addr, 0), lit[b]);
                check("t2_mask", log_q[b].mask, 9'h1FF);
                check("t2_last", log_q[b].last, 1'b1);
            end
        end

        // T3: address wrap.
        run_pass(4090, 9, 1, 1, 1'b0, -1, -1);
        check("t3_nbursts", log_q.size(), 1);
        if (log_q.size() == 1) begin
            lit = '{4090, 4091, 4092, 4093, 4094, 4095, 0, 1, 2};
            for (int k = 0; k < LANES; k++) check("t3_lane", lane(log_q[0].addr, k), lit[k]);
        end

        // T4: reset during WAIT of burst 2, then a fresh pass.
        run_pass(0, 49, 1, 1, 1'b0, 2, -1);
        check("t4_bursts_before_reset", log_q.size(), 3);
        run_pass(0, 49, 1, 1, 1'b0, -1, -1);
        check("t4_fresh_nbursts", log_q.size(), 6);
        if (log_q.size() != 0) check("t4_fresh_lane0", lane(log_q[0].addr, 0), 0);

        // T5: stray starts, readDone in ISSUE, 20-cycle RAM latency.
        run_pass(0, 49, 1, 0, 1'b1, -1, 20);
        check("t5_nbursts", log_q.size(), t1_log.size());
        for (int b = 0; b < log_q.size() && b < t1_log.size(); b++)
            check("t5_same_as_t1", log_q[b], t1_log[b]);

        // Illegal zero sizes are treated as 1.
        run_pass(7, 0, 0, 1, 1'b0, -1, -1);
        check("zero_nbursts", log_q.size(), 1);
        if (log_q.size() == 1) check("zero_mask", log_q[0].mask, 9'h001);

        // Randomized passes.
        for (int i = 0; i < 14; i++) begin
            run_pass(int'($urandom_range(0, 4095)), int'($urandom_range(1, 40)),
                     int'($urandom_range(1, 3)), 3, 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
